// File: rtl/pu_or1k_pfpu64_i2f_rnd_if.sv
// Handshake and data bundle between the i2f front stage and the i2f rounding stage.
// The front stage drives the normalisation hints; the rounding stage returns the result.
interface pu_or1k_pfpu64_i2f_rnd_if;
  logic        i2f_rdy_i;
  logic        i2f_sign_i;
  logic [3:0]  i2f_shr_i;
  logic [7:0]  i2f_exp8shr_i;
  logic [4:0]  i2f_shl_i;
  logic [7:0]  i2f_exp8shl_i;
  logic [7:0]  i2f_exp8sh0_i;
  logic [31:0] i2f_fract64_i;
  logic        i2f_rnd_rdy_o;
  logic [31:0] i2f_rnd_result_o;
  logic        i2f_rnd_ine_o;

  modport master (
    output i2f_rdy_i, i2f_sign_i, i2f_shr_i, i2f_exp8shr_i, i2f_shl_i,
           i2f_exp8shl_i, i2f_exp8sh0_i, i2f_fract64_i,
    input  i2f_rnd_rdy_o, i2f_rnd_result_o, i2f_rnd_ine_o
  );

  modport slave (
    input  i2f_rdy_i, i2f_sign_i, i2f_shr_i, i2f_exp8shr_i, i2f_shl_i,
           i2f_exp8shl_i, i2f_exp8sh0_i, i2f_fract64_i,
    output i2f_rnd_rdy_o, i2f_rnd_result_o, i2f_rnd_ine_o
  );
endinterface

// File: rtl/pu_or1k_pfpu64_i2f_rnd.sv
// Integer-to-float completion: stage A aligns the magnitude and extracts guard/sticky,
// stage B applies the IEEE-754 rounding increment and packs the single-precision result.
module pu_or1k_pfpu64_i2f_rnd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       adv_i,
  input  logic [1:0] rmode_i,
  pu_or1k_pfpu64_i2f_rnd_if.slave i2f
);

  logic [23:0] mant_a_s;
  logic [7:0]  exp_a_s;
  logic        guard_a_s;
  logic        sticky_a_s;
  logic [31:0] fract_shr_s;
  logic [31:0] fract_grd_s;
  logic [31:0] sticky_mask_s;

  logic        rdy_a_r;
  logic        sign_a_r;
  logic [1:0]  rmode_a_r;
  logic [23:0] mant_a_r;
  logic [7:0]  exp_a_r;
  logic        guard_a_r;
  logic        sticky_a_r;

  logic        inc_s;
  logic [24:0] sum_s;
  logic [23:0] mant_b_s;
  logic [7:0]  exp_b_s;

  logic        rdy_b_r;
  logic [31:0] result_r;
  logic        ine_r;

  // Alignment: pick the shift direction and collect bits shifted out to the right.
  always_comb begin
    mant_a_s      = 24'd0;
    exp_a_s       = 8'd0;
    guard_a_s     = 1'b0;
    sticky_a_s    = 1'b0;
    fract_shr_s   = i2f.i2f_fract64_i >> i2f.i2f_shr_i;
    fract_grd_s   = i2f.i2f_fract64_i >> (i2f.i2f_shr_i - 4'd1);
    // Mask covers bits below the guard position; empty when shr == 1.
    sticky_mask_s = (32'd1 << (i2f.i2f_shr_i - 4'd1)) - 32'd1;
    if (i2f.i2f_fract64_i == 32'd0) begin
      mant_a_s = 24'd0;
      exp_a_s  = 8'd0;
    end else if (i2f.i2f_shr_i != 4'd0) begin
      mant_a_s   = fract_shr_s[23:0];
      exp_a_s    = i2f.i2f_exp8shr_i;
      guard_a_s  = fract_grd_s[0];
      sticky_a_s = |(i2f.i2f_fract64_i & sticky_mask_s);
    end else if (i2f.i2f_fract64_i[23]) begin
      mant_a_s = i2f.i2f_fract64_i[23:0];
      exp_a_s  = i2f.i2f_exp8sh0_i;
    end else begin
      mant_a_s = i2f.i2f_fract64_i[23:0] << i2f.i2f_shl_i;
      exp_a_s  = i2f.i2f_exp8shl_i;
    end
  end

  // Stage A registers; flush only kills the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_a_r    <= 1'b0;
      sign_a_r   <= 1'b0;
      rmode_a_r  <= 2'd0;
      mant_a_r   <= 24'd0;
      exp_a_r    <= 8'd0;
      guard_a_r  <= 1'b0;
      sticky_a_r <= 1'b0;
    end else begin
      if (flush_i) begin
        rdy_a_r <= 1'b0;
      end else if (adv_i) begin
        rdy_a_r <= i2f.i2f_rdy_i;
      end
      if (adv_i) begin
        sign_a_r   <= i2f.i2f_sign_i;
        rmode_a_r  <= rmode_i;
        mant_a_r   <= mant_a_s;
        exp_a_r    <= exp_a_s;
        guard_a_r  <= guard_a_s;
        sticky_a_r <= sticky_a_s;
      end
    end
  end

  // Rounding increment and mantissa renormalisation on carry-out.
  always_comb begin
    case (rmode_a_r)
      2'd0:    inc_s = guard_a_r & (sticky_a_r | mant_a_r[0]);
      2'd1:    inc_s = 1'b0;
      2'd2:    inc_s = ~sign_a_r & (guard_a_r | sticky_a_r);
      2'd3:    inc_s = sign_a_r & (guard_a_r | sticky_a_r);
      default: inc_s = 1'b0;
    endcase
    sum_s = {1'b0, mant_a_r} + {24'd0, inc_s};
    if (sum_s[24]) begin
      mant_b_s = sum_s[24:1];
      exp_b_s  = exp_a_r + 8'd1;
    end else begin
      mant_b_s = sum_s[23:0];
      exp_b_s  = exp_a_r;
    end
  end

  // Stage B / output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_b_r  <= 1'b0;
      result_r <= 32'd0;
      ine_r    <= 1'b0;
    end else begin
      if (flush_i) begin
        rdy_b_r <= 1'b0;
      end else if (adv_i) begin
        rdy_b_r <= rdy_a_r;
      end
      if (adv_i) begin
        result_r <= {sign_a_r, exp_b_s, mant_b_s[22:0]};
        ine_r    <= guard_a_r | sticky_a_r;
      end
    end
  end

  assign i2f.i2f_rnd_rdy_o    = rdy_b_r;
  assign i2f.i2f_rnd_result_o = result_r;
  assign i2f.i2f_rnd_ine_o    = ine_r;

endmodule
